// File: rtl/vga_timing_gen_pkg.sv
// Shared video timing definitions: standard mode presets and derived raster positions.
// Default localparams describe the 640x480@60 mode used by most of the game designs.
package vga_timing_gen_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t Vga640x480At60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33
  };

  localparam vga_timing_t Vga800x600At60 = '{
    h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23
  };

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(32'(Vga640x480At60.h_active),
                                               32'(Vga640x480At60.h_fp),
                                               32'(Vga640x480At60.h_sync),
                                               32'(Vga640x480At60.h_bp));
  localparam int unsigned V_TOTAL = axis_total(32'(Vga640x480At60.v_active),
                                               32'(Vga640x480At60.v_fp),
                                               32'(Vga640x480At60.v_sync),
                                               32'(Vga640x480At60.v_bp));

  localparam int unsigned H_SYNC_START = 32'(Vga640x480At60.h_active) +
                                         32'(Vga640x480At60.h_fp);
  localparam int unsigned H_SYNC_END   = H_SYNC_START + 32'(Vga640x480At60.h_sync);
  localparam int unsigned V_SYNC_START = 32'(Vga640x480At60.v_active) +
                                         32'(Vga640x480At60.v_fp);
  localparam int unsigned V_SYNC_END   = V_SYNC_START + 32'(Vga640x480At60.v_sync);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active-region and sync flags.
// Flags are computed from the next count so they line up with the registered count.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned EW    = CNT_W + 1;

  localparam logic [CNT_W-1:0] LastPos   = CNT_W'(TOTAL - 1);
  // One spare bit so a sync region ending exactly at 2**CNT_W still compares correctly.
  localparam logic [EW-1:0]    ActEnd    = EW'(ACTIVE);
  localparam logic [EW-1:0]    SyncStart = EW'(ACTIVE + FP);
  localparam logic [EW-1:0]    SyncEnd   = EW'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_d;
  logic [EW-1:0]    count_ext;
  logic             in_sync;

  assign wrap = (count == LastPos);

  always_comb begin
    count_d = count;
    if (advance) begin
      count_d = wrap ? '0 : count + CNT_W'(1);
    end
  end

  assign count_ext = {1'b0, count_d};
  assign in_sync   = (count_ext >= SyncStart) && (count_ext < SyncEnd);

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      active <= 1'b1;
      sync   <= ~POL;
    end else begin
      count  <= count_d;
      active <= (count_ext < ActEnd);
      sync   <= in_sync ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, display flag and line/frame
// strobes, all registered together and advanced by a pixel clock-enable.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(Vga640x480At60.h_active),
  parameter int unsigned H_FP     = 32'(Vga640x480At60.h_fp),
  parameter int unsigned H_SYNC   = 32'(Vga640x480At60.h_sync),
  parameter int unsigned H_BP     = 32'(Vga640x480At60.h_bp),
  parameter int unsigned V_ACTIVE = 32'(Vga640x480At60.v_active),
  parameter int unsigned V_FP     = 32'(Vga640x480At60.v_fp),
  parameter int unsigned V_SYNC   = 32'(Vga640x480At60.v_sync),
  parameter int unsigned V_BP     = 32'(Vga640x480At60.v_bp),
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             in_disp_area,
  output logic             line_start,
  output logic             frame_start
);

  logic h_wrap;
  logic v_wrap;
  logic h_active;
  logic v_active;
  logic v_advance;

  // A line ends only on an enabled step out of the last column.
  assign v_advance = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clock   (clock),
    .reset   (reset),
    .advance (pix_en),
    .count   (hcount),
    .wrap    (h_wrap),
    .active  (h_active),
    .sync    (hsync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clock   (clock),
    .reset   (reset),
    .advance (v_advance),
    .count   (vcount),
    .wrap    (v_wrap),
    .active  (v_active),
    .sync    (vsync)
  );

  assign in_disp_area = h_active & v_active;

  always_ff @(posedge clock) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= v_advance;
      frame_start <= v_advance & v_wrap;
    end
  end

endmodule
